// File: rtl/fb_line_fetch.sv
// Framebuffer line prefetcher: fetches the next visible line into a ping-pong
// buffer over a req/ack read port and serves registered RGB to the VGA driver.
module fb_line_fetch #(
    parameter int              H_ACTIVE = 640,
    parameter int              V_ACTIVE = 480,
    parameter int              V_TOTAL  = 525,
    parameter int              ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] BASE   = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic              de,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              underrun,
    input  logic              underrun_clr
);
    localparam int IDX_W = $clog2(H_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [9:0] nl);
        logic [31:0] prod;
        prod = 32'(nl) * 32'(H_ACTIVE);
        return BASE + prod[ADDR_W-1:0];
    endfunction

    state_t             state_r, state_s;
    logic               bank_r, bank_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               restart_r, restart_s;
    logic [9:0]         pend_nl_r, pend_nl_s;
    logic               pend_ok_r, pend_ok_s;
    logic               req_s;
    logic [ADDR_W-1:0]  addr_s;
    logic               underrun_s;
    logic               wr_en_s;
    logic [23:0]        rgb_r;
    logic [23:0]        line_buf_r [2][H_ACTIVE];

    logic       trig_s;
    logic [9:0] nl_calc_s;
    logic       nl_ok_s;
    logic       ack_s;
    logic       show_s;

    assign trig_s    = enable && (px == 10'(H_ACTIVE));
    assign nl_calc_s = (py == 10'(V_TOTAL - 1)) ? 10'd0 : py + 10'd1;
    assign nl_ok_s   = nl_calc_s < 10'(V_ACTIVE);
    assign ack_s     = mem_ack && mem_req;
    assign show_s    = de && enable && (py < 10'(V_ACTIVE)) && (px < 10'(H_ACTIVE));

    // Next-state, request and write-enable logic for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        bank_s     = bank_r;
        idx_s      = idx_r;
        restart_s  = restart_r;
        pend_nl_s  = pend_nl_r;
        pend_ok_s  = pend_ok_r;
        req_s      = mem_req;
        addr_s     = mem_addr;
        underrun_s = underrun & ~underrun_clr;
        wr_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_s && nl_ok_s) begin
                    state_s   = ST_FETCH;
                    bank_s    = nl_calc_s[0];
                    idx_s     = {IDX_W{1'b0}};
                    req_s     = 1'b1;
                    addr_s    = line_addr(nl_calc_s);
                    restart_s = 1'b0;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_FETCH: begin
                if (!enable) begin
                    if (ack_s) begin
                        state_s   = ST_IDLE;
                        req_s     = 1'b0;
                        restart_s = 1'b0;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else begin
                    // A trigger mid-fetch is remembered until the in-flight word is acked.
                    if (trig_s) begin
                        underrun_s = 1'b1;
                        restart_s  = 1'b1;
                        pend_nl_s  = nl_calc_s;
                        pend_ok_s  = nl_ok_s;
                    end else begin
                        restart_s = restart_r;
                    end
                    if (!ack_s) begin
                        state_s = ST_FETCH;
                    end else begin
                        wr_en_s = 1'b1;
                        if (restart_s) begin
                            restart_s = 1'b0;
                            if (pend_ok_s) begin
                                bank_s = pend_nl_s[0];
                                idx_s  = {IDX_W{1'b0}};
                                addr_s = line_addr(pend_nl_s);
                            end else begin
                                state_s = ST_IDLE;
                                req_s   = 1'b0;
                            end
                        end else if (idx_r == IDX_W'(H_ACTIVE - 1)) begin
                            state_s = ST_IDLE;
                            req_s   = 1'b0;
                        end else begin
                            idx_s  = idx_r + IDX_W'(1);
                            addr_s = mem_addr + ADDR_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (ack_s) begin
                    state_s   = ST_IDLE;
                    req_s     = 1'b0;
                    restart_s = 1'b0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                req_s     = 1'b0;
                restart_s = 1'b0;
            end
        endcase
    end

    // FSM, request port and sticky underrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bank_r    <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            restart_r <= 1'b0;
            pend_nl_r <= 10'd0;
            pend_ok_r <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            underrun  <= 1'b0;
        end else begin
            state_r   <= state_s;
            bank_r    <= bank_s;
            idx_r     <= idx_s;
            restart_r <= restart_s;
            pend_nl_r <= pend_nl_s;
            pend_ok_r <= pend_ok_s;
            mem_req   <= req_s;
            mem_addr  <= addr_s;
            underrun  <= underrun_s;
        end
    end

    // Line buffer write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            line_buf_r[bank_r][idx_r] <= mem_rdata;
        end
    end

    // Registered pixel output, blanked outside the visible window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= 24'h000000;
        end else if (show_s) begin
            rgb_r <= line_buf_r[py[0]][px[IDX_W-1:0]];
        end else begin
            rgb_r <= 24'h000000;
        end
    end

    assign r = rgb_r[23:16];
    assign g = rgb_r[15:8];
    assign b = rgb_r[7:0];
endmodule

// File: tb/tb_fb_line_fetch.sv
// Directed bench for fb_line_fetch with a variable-latency memory model
// whose read data equals the word address.
module tb_fb_line_fetch;
    localparam logic [19:0] BASE = 20'h01000;

    logic        clk = 1'b0;
    logic        rst_n, enable, de, underrun_clr;
    logic [9:0]  px, py;
    logic        mem_req, mem_ack, underrun;
    logic [19:0] mem_addr;
    logic [23:0] mem_rdata;
    logic [7:0]  r, g, b;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt = 0;
    int req_hi_cnt = 0;
    int stab_viol = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [19:0] prev_addr = 20'h00000;
    logic [19:0] ack_log [$];

    always #5 clk = ~clk;

    fb_line_fetch #(
        .H_ACTIVE(640), .V_ACTIVE(480), .V_TOTAL(525), .ADDR_W(20), .BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .px(px), .py(py), .de(de),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .r(r), .g(g), .b(b),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = {4'h0, mem_addr};

    // Memory model plus handshake logger and stability monitor.
    always @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= 0;
            prev_req  <= 1'b0;
            prev_ack  <= 1'b0;
            prev_addr <= 20'h00000;
        end else begin
            if (prev_req && !prev_ack && (mem_req !== 1'b1 || mem_addr !== prev_addr))
                stab_viol <= stab_viol + 1;
            if (mem_req) req_hi_cnt <= req_hi_cnt + 1;
            if (mem_req && mem_ack) ack_log.push_back(mem_addr);
            wait_cnt  <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
            prev_req  <= mem_req;
            prev_ack  <= mem_ack;
            prev_addr <= mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic trigger(input logic [9:0] y);
        px = 10'd640;
        py = y;
        @(negedge clk);
        px = 10'd641;
    endtask

    task automatic wait_acks(input int base, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (ack_log.size() < base + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(ack_log.size() - base), 32'(n));
    endtask

    function automatic int seq_bad(input int st, input int n, input logic [19:0] a0);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (st + i >= ack_log.size()) bad++;
            else if (ack_log[st + i] !== a0 + 20'(i)) bad++;
        end
        return bad;
    endfunction

    initial begin
        int s, s2, hi, sa;
        logic [19:0] a;
        rst_n = 1'b0; enable = 1'b0; de = 1'b0; underrun_clr = 1'b0;
        px = 10'd0; py = 10'd0; lat = 0;
        tick(3);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(1);

        // 1: zero-latency fetch of line 0
        s = ack_log.size();
        trigger(10'd524);
        wait_acks(s, 640, 2000, "t1_ack_count");
        check("t1_addr_seq", 32'(seq_bad(s, 640, BASE)), 32'd0);
        tick(2);
        check("t1_req_idle", 32'(mem_req), 32'd0);
        py = 10'd0; px = 10'd5; de = 1'b1;
        tick(1);
        check("t1_rgb_px5", 32'({r, g, b}), 32'h001005);
        px = 10'd639;
        tick(1);
        check("t1_rgb_px639", 32'({r, g, b}), 32'h00127F);
        px = 10'd641;
        tick(1);
        check("t1_rgb_px641", 32'({r, g, b}), 32'd0);
        de = 1'b0;

        // 2: latency 3, line 1
        lat = 3;
        s = ack_log.size();
        trigger(10'd0);
        wait_acks(s, 640, 4000, "t2_ack_count");
        check("t2_addr_seq", 32'(seq_bad(s, 640, 20'h01280)), 32'd0);
        check("t2_last_addr", 32'(ack_log[s + 639]), 32'h014FF);
        check("t2_stable", 32'(stab_viol), 32'd0);
        check("t2_underrun", 32'(underrun), 32'd0);
        py = 10'd1; px = 10'd0; de = 1'b1;
        tick(1);
        check("t2_rgb_bank1", 32'({r, g, b}), 32'h001280);
        de = 1'b0;
        tick(2);

        // 3: latency 2 overruns the line; set beats clear
        lat = 2;
        trigger(10'd1);
        tick(796);
        check("t3_no_underrun_yet", 32'(underrun), 32'd0);
        s2 = ack_log.size();
        underrun_clr = 1'b1;
        trigger(10'd2);
        underrun_clr = 1'b0;
        check("t3_underrun_set", 32'(underrun), 32'd1);
        wait_acks(s2, 2, 20, "t3_two_acks");
        a = ack_log[s2];
        check("t3_old_word", 32'((a >= 20'h01500) && (a < 20'h01780)), 32'd1);
        check("t3_restart_addr", 32'(ack_log[s2 + 1]), 32'h01780);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        check("t3_underrun_clr", 32'(underrun), 32'd0);
        wait_acks(s2 + 1, 640, 2500, "t3_line3_count");
        check("t3_line3_seq", 32'(seq_bad(s2 + 1, 640, 20'h01780)), 32'd0);
        tick(2);
        check("t3_underrun_stays0", 32'(underrun), 32'd0);

        // 4: enable drops with an ack outstanding
        lat = 4;
        s = ack_log.size();
        trigger(10'd3);
        px = 10'd5; py = 10'd0; de = 1'b1;
        tick(1);
        check("t4_rgb_before", 32'({r, g, b}), 32'h001505);
        check("t4_req_high", 32'(mem_req), 32'd1);
        enable = 1'b0;
        tick(1);
        check("t4_rgb_off", 32'({r, g, b}), 32'd0);
        hi = 0;
        while (mem_req && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        check("t4_drain_cycles", 32'(hi), 32'd3);
        sa = req_hi_cnt;
        tick(10);
        check("t4_no_more_req", 32'(req_hi_cnt - sa), 32'd0);
        check("t4_one_ack", 32'(ack_log.size() - s), 32'd1);
        check("t4_ack_addr", 32'(ack_log[s]), 32'h01A00);
        check("t4_stable", 32'(stab_viol), 32'd0);

        // 5: asynchronous reset mid-fetch
        enable = 1'b1; lat = 3; de = 1'b0;
        trigger(10'd4);
        tick(5);
        check("t5_req_high", 32'(mem_req), 32'd1);
        px = 10'd5; py = 10'd0; de = 1'b1;
        tick(1);
        check("t5_rgb_before", 32'({r, g, b}), 32'h001505);
        rst_n = 1'b0;
        #1;
        check("t5_req_async", 32'(mem_req), 32'd0);
        check("t5_addr_async", 32'(mem_addr), 32'd0);
        check("t5_rgb_async", 32'({r, g, b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        de = 1'b0;
        sa = req_hi_cnt;
        tick(20);
        check("t5_no_req_after", 32'(req_hi_cnt - sa), 32'd0);

        // 6: line past V_ACTIVE is skipped; wrap trigger refetches line 0
        lat = 0;
        sa = req_hi_cnt;
        trigger(10'd479);
        tick(10);
        check("t6_no_req_479", 32'(req_hi_cnt - sa), 32'd0);
        s = ack_log.size();
        trigger(10'd524);
        wait_acks(s, 640, 2000, "t6_ack_count");
        check("t6_addr_seq", 32'(seq_bad(s, 640, BASE)), 32'd0);
        tick(2);
        px = 10'd5; py = 10'd0; de = 1'b0;
        tick(1);
        check("t6_de_low", 32'({r, g, b}), 32'd0);
        de = 1'b1;
        tick(1);
        check("t6_rgb_line0", 32'({r, g, b}), 32'h001005);
        py = 10'd480;
        tick(1);
        check("t6_py480", 32'({r, g, b}), 32'd0);
        check("t6_stable", 32'(stab_viol), 32'd0);
        check("t6_underrun", 32'(underrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
